ifu_fb_ctl: RTL and testbench

- Four-entry in-order fetch buffer sitting directly downstream of the fetch-pipe controller.
- Captures each F2 fetch group that hits, a 64-bit data chunk plus its PC, and presents the two oldest entries to the aligner.
- Returns the qualified consume strobes (ifu_fb_consume1/ifu_fb_consume2) that the fetch controller uses to mass-balance its fetch-buffer model.
- Flush empties the buffer.

---
 rtl/ifu_fb_ctl.sv | 139 +++++++++++++
 tb/tb_ifu_fb_ctl.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifu_fb_ctl.sv
// ifu_fb_ctl: in-order fetch buffer between the fetch-pipe controller and the aligner.
// Optional macro RV_IFU_FB_BYPASS_EN forwards an empty-buffer F2 hit combinationally to fb0.
module ifu_fb_ctl #(
    parameter int unsigned FB_DEPTH = 4,
    parameter int unsigned DATA_W   = 64
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          exu_flush_final,
    input  logic                          ifc_fetch_req_f2,
    input  logic                          ic_hit_f2,
    input  logic [30:0]                   ifc_fetch_addr_f2,
    input  logic [DATA_W-1:0]             ic_data_f2,
    input  logic                          ic_access_fault_f2,
    input  logic                          aln_take1,
    input  logic                          aln_take2,
    output logic                          fb0_valid,
    output logic                          fb1_valid,
    output logic [DATA_W-1:0]             fb0_data,
    output logic [DATA_W-1:0]             fb1_data,
    output logic [30:0]                   fb0_pc,
    output logic [30:0]                   fb1_pc,
    output logic                          fb0_fault,
    output logic                          fb1_fault,
    output logic                          ifu_fb_consume1,
    output logic                          ifu_fb_consume2,
    output logic [$clog2(FB_DEPTH+1)-1:0] fb_count,
    output logic                          fb_err
);
    localparam int unsigned CNT_W = $clog2(FB_DEPTH + 1);
    localparam int unsigned PC_W  = 31;

    logic [FB_DEPTH-1:0] r_valid;
    logic [FB_DEPTH-1:0] w_valid_nx;
    logic [DATA_W-1:0]   r_data     [FB_DEPTH];
    logic [DATA_W-1:0]   w_data_nx  [FB_DEPTH];
    logic [PC_W-1:0]     r_pc       [FB_DEPTH];
    logic [PC_W-1:0]     w_pc_nx    [FB_DEPTH];
    logic [FB_DEPTH-1:0] r_fault;
    logic [FB_DEPTH-1:0] w_fault_nx;
    logic [CNT_W-1:0]    r_count;
    logic [CNT_W-1:0]    w_count_nx;
    logic [CNT_W-1:0]    w_shift;
    logic [CNT_W-1:0]    w_base;
    logic                r_err;
    logic                w_err_nx;
    logic                w_wr;
    logic                w_take;
    logic                w_byp_take;
    logic                w_full_drop;
    logic                w_alloc;
    logic                w_under;

    assign w_wr   = ifc_fetch_req_f2 & ic_hit_f2 & ~exu_flush_final;
    assign w_take = aln_take1 | aln_take2;

`ifdef RV_IFU_FB_BYPASS_EN
    // Empty buffer: present the incoming F2 group as the oldest entry this cycle.
    logic w_byp;
    assign w_byp      = w_wr & (r_count == '0);
    assign fb0_valid  = r_valid[0] | w_byp;
    assign fb0_data   = w_byp ? ic_data_f2 : r_data[0];
    assign fb0_pc     = w_byp ? ifc_fetch_addr_f2 : r_pc[0];
    assign fb0_fault  = w_byp ? ic_access_fault_f2 : r_fault[0];
    assign w_byp_take = w_byp & w_take;
`else
    assign fb0_valid  = r_valid[0];
    assign fb0_data   = r_data[0];
    assign fb0_pc     = r_pc[0];
    assign fb0_fault  = r_fault[0];
    assign w_byp_take = 1'b0;
`endif

    assign fb1_valid = r_valid[1];
    assign fb1_data  = r_data[1];
    assign fb1_pc    = r_pc[1];
    assign fb1_fault = r_fault[1];
    assign fb_count  = r_count;
    assign fb_err    = r_err;

    assign ifu_fb_consume2 = aln_take2 & r_valid[1] & ~exu_flush_final;
    assign ifu_fb_consume1 = ~ifu_fb_consume2 & w_take & fb0_valid & ~exu_flush_final;
    assign w_under         = aln_take2 & fb0_valid & ~r_valid[1] & ~exu_flush_final;

    // A bypassed consume retires the F2 group directly, so nothing leaves storage.
    assign w_shift     = ifu_fb_consume2 ? CNT_W'(2) :
                         ((ifu_fb_consume1 & ~w_byp_take) ? CNT_W'(1) : '0);
    assign w_base      = r_count - w_shift;
    assign w_full_drop = w_wr & (w_base == CNT_W'(FB_DEPTH));
    assign w_alloc     = w_wr & ~w_full_drop & ~w_byp_take;

    // Next-state: shift out retired entries, then append the write behind the survivors.
    always_comb begin
        w_data_nx  = r_data;
        w_pc_nx    = r_pc;
        w_fault_nx = r_fault;
        w_valid_nx = '0;
        w_count_nx = exu_flush_final ? '0 : (w_base + CNT_W'(w_alloc));
        w_err_nx   = r_err | w_full_drop | w_under;
        for (int unsigned i = 0; i < FB_DEPTH; i++) begin
            if (w_shift != '0) begin
                for (int unsigned j = 0; j < FB_DEPTH; j++) begin
                    if (j == i + 32'(w_shift)) begin
                        w_data_nx[i]  = r_data[j];
                        w_pc_nx[i]    = r_pc[j];
                        w_fault_nx[i] = r_fault[j];
                    end
                end
            end
            if (w_alloc && (CNT_W'(i) == w_base)) begin
                w_data_nx[i]  = ic_data_f2;
                w_pc_nx[i]    = ifc_fetch_addr_f2;
                w_fault_nx[i] = ic_access_fault_f2;
            end
            w_valid_nx[i] = CNT_W'(i) < w_count_nx;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= '0;
            r_fault <= '0;
            r_count <= '0;
            r_err   <= 1'b0;
            for (int unsigned i = 0; i < FB_DEPTH; i++) begin
                r_data[i] <= '0;
                r_pc[i]   <= '0;
            end
        end else begin
            r_valid <= w_valid_nx;
            r_fault <= w_fault_nx;
            r_count <= w_count_nx;
            r_err   <= w_err_nx;
            r_data  <= w_data_nx;
            r_pc    <= w_pc_nx;
        end
    end

endmodule

// File: tb/tb_ifu_fb_ctl.sv
// tb_ifu_fb_ctl: queue-model bench for ifu_fb_ctl, directed scenarios then randomized traffic.
// Follows RV_IFU_FB_BYPASS_EN the same way the design does.
module tb_ifu_fb_ctl;
    localparam int unsigned DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        exu_flush_final;
    logic        ifc_fetch_req_f2;
    logic        ic_hit_f2;
    logic [30:0] ifc_fetch_addr_f2;
    logic [63:0] ic_data_f2;
    logic        ic_access_fault_f2;
    logic        aln_take1;
    logic        aln_take2;
    logic        fb0_valid, fb1_valid;
    logic [63:0] fb0_data, fb1_data;
    logic [30:0] fb0_pc, fb1_pc;
    logic        fb0_fault, fb1_fault;
    logic        ifu_fb_consume1, ifu_fb_consume2;
    logic [2:0]  fb_count;
    logic        fb_err;

    always #5 clk = ~clk;

    ifu_fb_ctl #(.FB_DEPTH(DEPTH), .DATA_W(64)) dut (
        .clk(clk), .rst(rst), .exu_flush_final(exu_flush_final),
        .ifc_fetch_req_f2(ifc_fetch_req_f2), .ic_hit_f2(ic_hit_f2),
        .ifc_fetch_addr_f2(ifc_fetch_addr_f2), .ic_data_f2(ic_data_f2),
        .ic_access_fault_f2(ic_access_fault_f2), .aln_take1(aln_take1), .aln_take2(aln_take2),
        .fb0_valid(fb0_valid), .fb1_valid(fb1_valid), .fb0_data(fb0_data), .fb1_data(fb1_data),
        .fb0_pc(fb0_pc), .fb1_pc(fb1_pc), .fb0_fault(fb0_fault), .fb1_fault(fb1_fault),
        .ifu_fb_consume1(ifu_fb_consume1), .ifu_fb_consume2(ifu_fb_consume2),
        .fb_count(fb_count), .fb_err(fb_err)
    );

    typedef struct {
        logic [63:0] d;
        logic [30:0] pc;
        logic        f;
    } ent_t;

    ent_t q[$];
    logic m_err = 1'b0;
    int   n_pass = 0;
    int   n_total = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        else n_pass++;
    endtask

    function automatic logic wr_now();
        return ifc_fetch_req_f2 && ic_hit_f2 && !exu_flush_final;
    endfunction

    function automatic logic byp_now();
`ifdef RV_IFU_FB_BYPASS_EN
        return wr_now() && (q.size() == 0);
`else
        return 1'b0;
`endif
    endfunction

    task automatic drive(input logic req, input logic hit, input logic [30:0] pc, input logic [63:0] d,
                         input logic f, input logic t1, input logic t2, input logic fl);
        ifc_fetch_req_f2   = req;
        ic_hit_f2          = hit;
        ifc_fetch_addr_f2  = pc;
        ic_data_f2         = d;
        ic_access_fault_f2 = f;
        aln_take1          = t1;
        aln_take2          = t2;
        exu_flush_final    = fl;
    endtask

    // Compare every DUT output against the queue view of the buffer.
    task automatic cmp_cycle();
        ent_t e0, e1;
        logic v0, v1, c1, c2, byp;
        int   sz;
        sz  = q.size();
        byp = byp_now();
        v0  = (sz > 0) || byp;
        v1  = sz > 1;
        if (byp) e0 = '{d: ic_data_f2, pc: ifc_fetch_addr_f2, f: ic_access_fault_f2};
        else if (sz > 0) e0 = q[0];
        if (v1) e1 = q[1];
        c2 = aln_take2 && v1 && !exu_flush_final;
        c1 = !c2 && (aln_take1 || aln_take2) && v0 && !exu_flush_final;
        chk("fb0_valid", 64'(fb0_valid), 64'(v0));
        chk("fb1_valid", 64'(fb1_valid), 64'(v1));
        chk("fb_count", 64'(fb_count), 64'(sz));
        chk("fb_err", 64'(fb_err), 64'(m_err));
        chk("consume1", 64'(ifu_fb_consume1), 64'(c1));
        chk("consume2", 64'(ifu_fb_consume2), 64'(c2));
        if (v0) begin
            chk("fb0_data", fb0_data, e0.d);
            chk("fb0_pc", 64'(fb0_pc), 64'(e0.pc));
            chk("fb0_fault", 64'(fb0_fault), 64'(e0.f));
        end
        if (v1) begin
            chk("fb1_data", fb1_data, e1.d);
            chk("fb1_pc", 64'(fb1_pc), 64'(e1.pc));
            chk("fb1_fault", 64'(fb1_fault), 64'(e1.f));
        end
    endtask

    task automatic model_update();
        logic v0, v1, c1, c2, byp;
        int   sz;
        sz  = q.size();
        byp = byp_now();
        v0  = (sz > 0) || byp;
        v1  = sz > 1;
        c2  = aln_take2 && v1 && !exu_flush_final;
        c1  = !c2 && (aln_take1 || aln_take2) && v0 && !exu_flush_final;
        if (exu_flush_final) begin
            q.delete();
            return;
        end
        if (aln_take2 && v0 && !v1) m_err = 1'b1;
        if (c2) begin
            void'(q.pop_front());
            void'(q.pop_front());
        end else if (c1 && !byp) begin
            void'(q.pop_front());
        end
        if (wr_now() && !(byp && (aln_take1 || aln_take2))) begin
            if (q.size() >= DEPTH) m_err = 1'b1;
            else q.push_back('{d: ic_data_f2, pc: ifc_fetch_addr_f2, f: ic_access_fault_f2});
        end
    endtask

    task automatic step(input logic req, input logic hit, input logic [30:0] pc, input logic [63:0] d,
                        input logic f, input logic t1, input logic t2, input logic fl);
        drive(req, hit, pc, d, f, t1, t2, fl);
        #1;
        cmp_cycle();
    endtask

    task automatic tick();
        model_update();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic hit(input logic [30:0] pc);
        step(1'b1, 1'b1, pc, {32'hC0DE0000, 1'b0, pc}, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        chk("rst_async_count", 64'(fb_count), 64'd0);
        chk("rst_async_valid", 64'(fb0_valid), 64'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        q.delete();
        m_err = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
        repeat (2) @(negedge clk);
        #1;
        chk("reset_count", 64'(fb_count), 64'd0);
        chk("reset_fb0_valid", 64'(fb0_valid), 64'd0);
        chk("reset_fb1_valid", 64'(fb1_valid), 64'd0);
        chk("reset_err", 64'(fb_err), 64'd0);
        chk("reset_fb0_data", fb0_data, 64'd0);
        chk("reset_fb0_pc", 64'(fb0_pc), 64'd0);
        chk("reset_consume1", 64'(ifu_fb_consume1), 64'd0);
        chk("reset_consume2", 64'(ifu_fb_consume2), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // Fill to capacity, then overflow.
        hit(31'h100); hit(31'h104); hit(31'h108); hit(31'h10C);
        chk("fill_count", 64'(fb_count), 64'd4);
        chk("fill_fb0_pc", 64'(fb0_pc), 64'h100);
        chk("fill_fb1_pc", 64'(fb1_pc), 64'h104);
        chk("fill_err", 64'(fb_err), 64'd0);
        hit(31'h110);
        chk("ovf_count", 64'(fb_count), 64'd4);
        chk("ovf_err", 64'(fb_err), 64'd1);

        // Take two while writing at count 3.
        do_reset();
        hit(31'h10); hit(31'h20); hit(31'h30);
        step(1'b1, 1'b1, 31'h40, 64'hD, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("t2w_consume2", 64'(ifu_fb_consume2), 64'd1);
        chk("t2w_consume1", 64'(ifu_fb_consume1), 64'd0);
        tick();
        chk("t2w_count", 64'(fb_count), 64'd2);
        chk("t2w_fb0_pc", 64'(fb0_pc), 64'h30);
        chk("t2w_fb1_pc", 64'(fb1_pc), 64'h40);

        // Under-run: take2 with one entry.
        do_reset();
        hit(31'h50);
        step(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("under_consume1", 64'(ifu_fb_consume1), 64'd1);
        chk("under_consume2", 64'(ifu_fb_consume2), 64'd0);
        tick();
        chk("under_count", 64'(fb_count), 64'd0);
        chk("under_err", 64'(fb_err), 64'd1);

        // Flush at full with a write and a take.
        do_reset();
        hit(31'h1); hit(31'h2); hit(31'h3); hit(31'h4);
        step(1'b1, 1'b1, 31'h99, 64'h99, 1'b0, 1'b1, 1'b0, 1'b1);
        chk("flush_consume1", 64'(ifu_fb_consume1), 64'd0);
        chk("flush_consume2", 64'(ifu_fb_consume2), 64'd0);
        tick();
        chk("flush_count", 64'(fb_count), 64'd0);
        chk("flush_fb0_valid", 64'(fb0_valid), 64'd0);
        chk("flush_err", 64'(fb_err), 64'd0);

        // Miss does not allocate; faulted hit keeps its fault.
        do_reset();
        hit(31'h60); hit(31'h70);
        step(1'b1, 1'b0, 31'h80, 64'h80, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        chk("miss_count", 64'(fb_count), 64'd2);
        step(1'b1, 1'b1, 31'h300, 64'h300, 1'b1, 1'b0, 1'b1, 1'b0);
        tick();
        chk("fault_count", 64'(fb_count), 64'd1);
        chk("fault_fb0_pc", 64'(fb0_pc), 64'h300);
        chk("fault_fb0_fault", 64'(fb0_fault), 64'd1);

        // Empty-buffer hit with a take.
        do_reset();
        step(1'b1, 1'b1, 31'h200, 64'h200, 1'b0, 1'b1, 1'b0, 1'b0);
`ifdef RV_IFU_FB_BYPASS_EN
        chk("byp_fb0_valid", 64'(fb0_valid), 64'd1);
        chk("byp_fb0_pc", 64'(fb0_pc), 64'h200);
        chk("byp_consume1", 64'(ifu_fb_consume1), 64'd1);
        tick();
        chk("byp_count", 64'(fb_count), 64'd0);
`else
        chk("nobyp_fb0_valid", 64'(fb0_valid), 64'd0);
        chk("nobyp_consume1", 64'(ifu_fb_consume1), 64'd0);
        tick();
        chk("nobyp_count", 64'(fb_count), 64'd1);
        chk("nobyp_fb0_pc", 64'(fb0_pc), 64'h200);
`endif

        // Randomized traffic with phases of light, balanced and heavy draining.
        do_reset();
        for (int n = 0; n < 1500; n++) begin
            int   ph;
            logic rq, ht, t1, t2, fl;
            if (n == 700) do_reset();
            ph = (n / 100) % 3;
            rq = $urandom_range(0, 9) < 7;
            ht = $urandom_range(0, 9) < 8;
            fl = $urandom_range(0, 29) == 0;
            t1 = $urandom_range(0, 9) < (ph == 0 ? 1 : (ph == 1 ? 4 : 6));
            t2 = $urandom_range(0, 9) < (ph == 0 ? 1 : (ph == 1 ? 3 : 5));
            step(rq, ht, 31'($urandom), {$urandom, $urandom}, 1'($urandom), t1, t2, fl);
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
